// File: rtl/sp_ram_pkg.sv
// Shared constants for the byte-enable single-port RAM: read-during-write
// mode codes and the clear/ready state encoding.
package sp_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    typedef logic state_t;
    localparam state_t CLEAR = 1'b0;
    localparam state_t READY = 1'b1;

endpackage

// File: rtl/single_port_ram_be_core.sv
// Storage array with byte-lane writes and a registered read-first read port.
module sp_ram_core #(
    parameter int addr_width = 6,
    parameter int data_width = 32,
    parameter int depth      = 64
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [data_width/8-1:0] be,
    input  logic [addr_width-1:0]   addr,
    input  logic [data_width-1:0]   data,
    input  logic                    re,
    output logic [data_width-1:0]   q
);

    localparam int unsigned LANES = data_width / 8;

    logic [data_width-1:0] mem [depth];

    // Read and write share one edge; the read sees the word before the write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= data[8*i +: 8];
            end
        end
        if (re) q <= mem[addr];
    end

endmodule

// File: rtl/single_port_ram_be.sv
// Single-port RAM with byte enables, selectable read-during-write behaviour,
// optional output register and a post-reset hardware clear of the array.
module single_port_ram_be
    import sp_ram_pkg::*;
#(
    parameter int addr_width = 6,
    parameter int data_width = 32,
    parameter int depth      = 64,
    parameter int rdw_mode   = 0,
    parameter int out_reg    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    we,
    input  logic [data_width/8-1:0] be,
    input  logic [addr_width-1:0]   addr,
    input  logic [data_width-1:0]   data,
    output logic [data_width-1:0]   q,
    output logic                    q_valid,
    output logic                    busy
);

    localparam int unsigned LANES = data_width / 8;
    localparam logic [addr_width-1:0] LAST = addr_width'(depth - 1);

    if (data_width % 8 != 0) begin : g_chk_width
        $error("single_port_ram_be: data_width must be a multiple of 8");
    end
    if (depth > (1 << addr_width)) begin : g_chk_depth
        $error("single_port_ram_be: depth exceeds address space");
    end
    if (rdw_mode > 2) begin : g_chk_mode
        $error("single_port_ram_be: rdw_mode must be 0, 1 or 2");
    end

    state_t                state;
    logic [addr_width-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            if (clr_cnt == LAST) state <= READY;
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    assign busy = (state == CLEAR);

    logic in_range, acc, out_ev;
    assign in_range = int'(addr) < depth;
    assign acc      = en && !busy && !rst;
    assign out_ev   = acc && !(we && rdw_mode == RDW_NO_CHANGE);

    logic                    c_we, c_re;
    logic [LANES-1:0]        c_be;
    logic [addr_width-1:0]   c_addr;
    logic [data_width-1:0]   c_data, c_q;

    always_comb begin
        c_we   = 1'b0;
        c_be   = be;
        c_addr = addr;
        c_data = data;
        if (busy) begin
            c_we   = 1'b1;
            c_be   = '1;
            c_addr = clr_cnt;
            c_data = '0;
        end else if (acc && we && in_range) begin
            c_we = 1'b1;
        end
    end

    assign c_re = out_ev && in_range;

    sp_ram_core #(
        .addr_width (addr_width),
        .data_width (data_width),
        .depth      (depth)
    ) u_core (
        .clk  (clk),
        .we   (c_we),
        .be   (c_be),
        .addr (c_addr),
        .data (c_data),
        .re   (c_re),
        .q    (c_q)
    );

    // Side info is only captured on output-producing accesses so the
    // combined result holds its value along with the core read register.
    logic                  s1_valid, s1_zero, s1_wf;
    logic [data_width-1:0] s1_data, q1;
    logic [LANES-1:0]      s1_be;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b1;
            s1_wf    <= 1'b0;
            s1_data  <= '0;
            s1_be    <= '0;
        end else begin
            s1_valid <= out_ev;
            if (out_ev) begin
                s1_zero <= !in_range;
                s1_wf   <= we && (rdw_mode == RDW_WRITE_FIRST);
                s1_data <= data;
                s1_be   <= be;
            end
        end
    end

    always_comb begin
        q1 = c_q;
        if (s1_wf) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (s1_be[i]) q1[8*i +: 8] = s1_data[8*i +: 8];
            end
        end
        if (s1_zero) q1 = '0;
    end

    if (out_reg != 0) begin : g_oreg
        logic [data_width-1:0] q_r;
        logic                  v_r;
        always_ff @(posedge clk) begin
            if (rst) begin
                q_r <= '0;
                v_r <= 1'b0;
            end else begin
                v_r <= s1_valid;
                if (s1_valid) q_r <= q1;
            end
        end
        assign q       = q_r;
        assign q_valid = v_r;
    end else begin : g_direct
        assign q       = q1;
        assign q_valid = s1_valid;
    end

endmodule

// File: tb/tb_single_port_ram_be.sv
// Drives three differently configured RAM instances with shared stimulus and
// compares each against a word-array reference model every cycle.
module tb_single_port_ram_be;

    logic        clk, rst, en, we;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] q_o [3];
    logic        qv_o [3];
    logic        busy_o [3];

    int checks = 0;
    int passed = 0;

    // Reference model: dut 0 read-first, dut 1 write-first + out_reg, dut 2 no-change depth 48
    int          dep [3];
    int          mode [3];
    int          oreg [3];
    logic [31:0] mem [3][64];
    int          busy_left [3];
    logic        v1 [3], v2 [3];
    logic [31:0] q1 [3], q2 [3];

    single_port_ram_be #(.addr_width(6), .data_width(32), .depth(64), .rdw_mode(0), .out_reg(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .data(data),
        .q(q_o[0]), .q_valid(qv_o[0]), .busy(busy_o[0]));
    single_port_ram_be #(.addr_width(6), .data_width(32), .depth(64), .rdw_mode(1), .out_reg(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .data(data),
        .q(q_o[1]), .q_valid(qv_o[1]), .busy(busy_o[1]));
    single_port_ram_be #(.addr_width(6), .data_width(32), .depth(48), .rdw_mode(2), .out_reg(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .data(data),
        .q(q_o[2]), .q_valid(qv_o[2]), .busy(busy_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_edge(int k, logic r, logic e, logic w,
                                       logic [3:0] b, logic [5:0] a, logic [31:0] d);
        logic        prod;
        logic [31:0] res, old, nw;
        bit          inr;
        prod = 1'b0;
        res  = '0;
        if (r) begin
            for (int i = 0; i < 64; i++) mem[k][i] = '0;
            busy_left[k] = dep[k];
            v1[k] = 1'b0; v2[k] = 1'b0; q1[k] = '0; q2[k] = '0;
            return;
        end
        if (busy_left[k] > 0) begin
            busy_left[k]--;
        end else if (e) begin
            inr = int'(a) < dep[k];
            old = inr ? mem[k][a] : 32'h0;
            if (w) begin
                nw = old;
                for (int i = 0; i < 4; i++) if (b[i]) nw[8*i +: 8] = d[8*i +: 8];
                if (inr) mem[k][a] = nw;
                prod = (mode[k] != 2);
                res  = !inr ? 32'h0 : (mode[k] == 1 ? nw : old);
            end else begin
                prod = 1'b1;
                res  = old;
            end
        end
        if (oreg[k] != 0) begin
            if (v1[k]) q2[k] = q1[k];
            v2[k] = v1[k];
        end
        v1[k] = prod;
        if (prod) q1[k] = res;
    endfunction

    function automatic logic xv(int k);
        return (oreg[k] != 0) ? v2[k] : v1[k];
    endfunction

    function automatic logic [31:0] xq(int k);
        return (oreg[k] != 0) ? q2[k] : q1[k];
    endfunction

    task automatic step(input logic r, input logic e, input logic w,
                        input logic [3:0] b, input logic [5:0] a, input logic [31:0] d);
        rst = r; en = e; we = w; be = b; addr = a; data = d;
        for (int k = 0; k < 3; k++) model_edge(k, r, e, w, b, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (q_o[k] !== 32'h0 || qv_o[k] !== 1'b0 || busy_o[k] !== 1'b1)
                $display("FAIL reset_state dut%0d: q=%h q_valid=%b busy=%b, expected q=0 q_valid=0 busy=1",
                         k, q_o[k], qv_o[k], busy_o[k]);
            else passed++;
        end
        for (int c = 0; c < 66; c++) begin
            step(1'b0, 1'b1, 1'b0, 4'h0, 6'(c), 32'h0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (qv_o[k] !== xv(k) || q_o[k] !== xq(k) || busy_o[k] !== (busy_left[k] > 0))
                    $display("FAIL clear_busy dut%0d cyc%0d: q=%h q_valid=%b busy=%b, expected q=%h q_valid=%b busy=%b",
                             k, c, q_o[k], qv_o[k], busy_o[k], xq(k), xv(k), busy_left[k] > 0);
                else passed++;
            end
        end
    endtask

    task automatic test_read_all();
        for (int c = 0; c < 66; c++) begin
            step(1'b0, c < 64, 1'b0, 4'h0, 6'(c), 32'h0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (qv_o[k] !== xv(k) || q_o[k] !== xq(k) || busy_o[k] !== 1'b0)
                    $display("FAIL read_all dut%0d cyc%0d: q=%h q_valid=%b busy=%b, expected q=%h q_valid=%b busy=0",
                             k, c, q_o[k], qv_o[k], busy_o[k], xq(k), xv(k));
                else passed++;
            end
        end
    endtask

    task automatic test_byte_enable();
        step(1'b0, 1'b1, 1'b1, 4'b1111, 6'd5, 32'hDEADBEEF);
        step(1'b0, 1'b1, 1'b1, 4'b0010, 6'd5, 32'h0000AA00);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 6'd5, 32'h0);
        checks++;
        if (q_o[0] !== 32'hDEADAAEF || qv_o[0] !== 1'b1)
            $display("FAIL byte_enable_read: q=%h q_valid=%b, expected q=deadaaef q_valid=1", q_o[0], qv_o[0]);
        else passed++;
        step(1'b0, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (qv_o[k] !== xv(k) || q_o[k] !== xq(k))
                $display("FAIL byte_enable dut%0d: q=%h q_valid=%b, expected q=%h q_valid=%b",
                         k, q_o[k], qv_o[k], xq(k), xv(k));
            else passed++;
        end
    endtask

    task automatic test_rdw_modes();
        logic [31:0] c_before;
        step(1'b0, 1'b1, 1'b1, 4'hF, 6'd3, 32'h11111111);
        c_before = xq(2);
        step(1'b0, 1'b1, 1'b1, 4'hF, 6'd3, 32'h22222222);
        checks++;
        if (q_o[0] !== 32'h11111111 || qv_o[0] !== 1'b1)
            $display("FAIL rdw_read_first: q=%h q_valid=%b, expected q=11111111 q_valid=1", q_o[0], qv_o[0]);
        else passed++;
        checks++;
        if (qv_o[2] !== 1'b0 || q_o[2] !== c_before)
            $display("FAIL rdw_no_change: q=%h q_valid=%b, expected q=%h q_valid=0", q_o[2], qv_o[2], c_before);
        else passed++;
        step(1'b0, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        checks++;
        if (q_o[1] !== 32'h22222222 || qv_o[1] !== 1'b1)
            $display("FAIL rdw_write_first: q=%h q_valid=%b, expected q=22222222 q_valid=1", q_o[1], qv_o[1]);
        else passed++;
    endtask

    task automatic test_out_reg();
        for (int c = 0; c < 5; c++) begin
            step(1'b0, c < 3, 1'b0, 4'h0, 6'(c), 32'h0);
            checks++;
            if (qv_o[1] !== (c >= 1 && c <= 3) || q_o[1] !== xq(1))
                $display("FAIL out_reg_latency cyc%0d: q=%h q_valid=%b, expected q=%h q_valid=%b",
                         c, q_o[1], qv_o[1], xq(1), (c >= 1 && c <= 3));
            else passed++;
        end
    endtask

    task automatic test_out_of_range();
        step(1'b0, 1'b1, 1'b1, 4'hF, 6'd50, 32'h000000FF);
        step(1'b0, 1'b1, 1'b0, 4'h0, 6'd50, 32'h0);
        checks++;
        if (q_o[2] !== 32'h0 || qv_o[2] !== 1'b1)
            $display("FAIL oor_read: q=%h q_valid=%b, expected q=0 q_valid=1", q_o[2], qv_o[2]);
        else passed++;
        checks++;
        if (q_o[0] !== 32'h000000FF || qv_o[0] !== 1'b1)
            $display("FAIL in_range_50: q=%h q_valid=%b, expected q=000000ff q_valid=1", q_o[0], qv_o[0]);
        else passed++;
    endtask

    task automatic test_random();
        logic e, w;
        for (int c = 0; c < 400; c++) begin
            e = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) != 0;
            step(1'b0, e, w, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), $urandom);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (qv_o[k] !== xv(k) || q_o[k] !== xq(k) || busy_o[k] !== 1'b0)
                    $display("FAIL random dut%0d cyc%0d: q=%h q_valid=%b busy=%b, expected q=%h q_valid=%b busy=0",
                             k, c, q_o[k], qv_o[k], busy_o[k], xq(k), xv(k));
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        // request just before reset must not surface on the registered output
        step(1'b0, 1'b1, 1'b0, 4'h0, 6'd5, 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        checks++;
        if (qv_o[1] !== 1'b0 || q_o[1] !== 32'h0 || busy_o[1] !== 1'b1)
            $display("FAIL reset_discard: q=%h q_valid=%b busy=%b, expected q=0 q_valid=0 busy=1",
                     q_o[1], qv_o[1], busy_o[1]);
        else passed++;
        for (int c = 0; c < 30; c++) step(1'b0, 1'b1, 1'b1, 4'hF, 6'(c), 32'hFFFFFFFF);
        step(1'b1, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        for (int c = 0; c < 66; c++) begin
            step(1'b0, 1'b1, 1'b0, 4'h0, 6'(c), 32'h0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (qv_o[k] !== xv(k) || q_o[k] !== xq(k) || busy_o[k] !== (busy_left[k] > 0))
                    $display("FAIL reset_mid dut%0d cyc%0d: q=%h q_valid=%b busy=%b, expected q=%h q_valid=%b busy=%b",
                             k, c, q_o[k], qv_o[k], busy_o[k], xq(k), xv(k), busy_left[k] > 0);
                else passed++;
            end
        end
    endtask

    initial begin
        dep[0] = 64; mode[0] = 0; oreg[0] = 0;
        dep[1] = 64; mode[1] = 1; oreg[1] = 1;
        dep[2] = 48; mode[2] = 2; oreg[2] = 0;
        rst = 1'b1; en = 1'b0; we = 1'b0; be = '0; addr = '0; data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_read_all();
        test_byte_enable();
        test_rdw_modes();
        test_out_reg();
        test_out_of_range();
        test_random();
        test_reset_mid();
        test_random();
        test_reset_mid();
        test_read_all();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/single_port_ram_be.md
# single_port_ram_be

Parametrised single-port synchronous RAM, next generation of the team's basic single-port memory. It adds per-byte write enables, a selectable read-during-write mode, and an optional output register stage with a read-valid strobe. A post-reset hardware clear sequencer zeroes the array before accepting accesses. It sits as a general scratch or buffer memory behind datapath blocks that need known-zero contents after reset.

## Interface
- addr_width, 6, address bits
- data_width, 32, word width; must be a multiple of 8
- depth, 64, number of words; must be ≤ 2^addr_width
- rdw_mode, 0, read-during-write behaviour: 0 read-first, 1 write-first, 2 no-change
- out_reg, 0, 1 adds one output pipeline stage
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  access request this cycle
- we  in  1  write when en=1 (else read)
- be  in  data_width/8  byte-lane write enables, bit i covers data[8i+7:8i]
- addr  in  addr_width  word address
- data  in  data_width  write data
- q  out  data_width  read data
- q_valid  out  1  one-cycle strobe: q carries the result of an accepted access
- busy  out  1  clear sequence in progress; requests ignored

## Operation
- States: CLEAR, READY. rst forces CLEAR with clear counter = 0.
- CLEAR: each cycle writes 0 to ram[counter] and increments the counter. At counter = depth-1, the block moves to READY on the next edge. busy=1 throughout. en is ignored and no q_valid is produced.
- READY: busy=0. A request with en=1 is accepted every cycle; there is no backpressure.
- Read (en=1, we=0): q ← ram[addr].
- Write (en=1, we=1): for each lane with be[i]=1, ram[addr] lane i ← data lane i. Other lanes are unchanged. be=0 is a legal no-op write.
- Read-during-write output on a write:
  - mode 0: q ← old word and q_valid pulses.
  - mode 1: q ← merged new word and q_valid pulses.
  - mode 2: q and q_valid are unchanged/low.
- Out-of-range address (addr ≥ depth): a write is dropped. A read returns 0 with q_valid=1.
- en=0: q holds its last value and q_valid=0.
- rst in any state: returns to CLEAR and restarts from address 0. Array contents are then fully re-zeroed.

## Timing
- Reset values:
  - q=0, q_valid=0, busy=1.
  - Output pipeline register = 0, valid = 0.
- Clear duration: busy falls exactly depth cycles after the last cycle with rst=1. The first request is accepted on that cycle.
- Read latency, counted from the accepting edge:
  - out_reg=0: q/q_valid valid after 1 edge.
  - out_reg=1: valid after 2 edges.
- Back-to-back requests produce back-to-back q_valid pulses, in request order.
- Write followed by a read of the same address on the next cycle returns the new data in all modes.
- With out_reg=1, a request accepted on the cycle before rst is discarded; q_valid stays 0.

## Structure
- Package sp_ram_pkg holds:
  - rdw_mode constants RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, RDW_NO_CHANGE=2.
  - The state typedef {CLEAR, READY}.
- Sub-module sp_ram_core holds the storage array with the byte-lane write and the registered read. The top level holds the clear FSM, the mode mux, the output stage and the valid logic.
- Elaboration checks: data_width%8==0, depth ≤ 2^addr_width, rdw_mode ≤ 2.

## Test plan
- Reset then idle (depth=64): busy=1 for 64 cycles, then 0. Read every address → all q=0, each with one q_valid.
- Write 0xDEADBEEF to addr 5 with be=4'b1111, then be=4'b0010 with data 0x0000AA00 → read addr 5 returns 0xDEADAAEF.
- Cover each rdw_mode: write 0x11111111 then 0x22222222 to addr 3.
  - Mode 0: second write gives q=0x11111111.
  - Mode 1: q=0x22222222.
  - Mode 2: no q_valid, q unchanged.
- out_reg=1, reads to addrs 0,1,2 on consecutive cycles → q_valid high on cycles 2,3,4 with the matching data.
- Assert rst for 1 cycle at clear counter=30 and again after data was written → busy for a full 64 cycles afterwards, and all reads return 0.
- depth=48, addr_width=6: write 0xFF to addr 50 → no array change. Read addr 50 → q=0 with q_valid=1.
